// File: rtl/hdmi_pkg.sv
// Shared encodings for the HDMI period scheduler: TMDS channel modes, preamble
// control words, period lengths and the data-island state type.
package hdmi_pkg;

  localparam logic [2:0] MODE_CONTROL      = 3'd0;
  localparam logic [2:0] MODE_VIDEO        = 3'd1;
  localparam logic [2:0] MODE_VIDEO_GUARD  = 3'd2;
  localparam logic [2:0] MODE_ISLAND       = 3'd3;
  localparam logic [2:0] MODE_ISLAND_GUARD = 3'd4;

  typedef struct packed {
    logic [1:0] ctl1;
    logic [1:0] ctl2;
  } ctl_pair_t;

  localparam ctl_pair_t CTL_NONE       = '{ctl1: 2'b00, ctl2: 2'b00};
  localparam ctl_pair_t CTL_VIDEO_PRE  = '{ctl1: 2'b01, ctl2: 2'b00};
  localparam ctl_pair_t CTL_ISLAND_PRE = '{ctl1: 2'b01, ctl2: 2'b01};

  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;
  localparam int PACKET_LEN   = 32;

  typedef enum logic [2:0] {
    ISL_IDLE,
    ISL_PREAMBLE,
    ISL_LEAD_GUARD,
    ISL_PACKET,
    ISL_TRAIL_GUARD
  } island_state_t;

endpackage

// File: rtl/hdmi_timing_counter.sv
// Raster position counters with registered syncs, plus look-ahead flags for the
// pixel that will be presented on the next clock.
module hdmi_timing_counter #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0
) (
  input  logic        clk_pixel,
  input  logic        reset,
  output logic [11:0] cx,
  output logic [10:0] cy,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] next_cx,
  output logic        next_active,
  output logic        next_line_active
);

  localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [10:0] V_LAST   = 11'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [11:0] HS_FIRST = 12'(H_ACTIVE + H_FRONT);
  localparam logic [11:0] HS_LAST  = 12'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic        HS_ON    = 1'(HSYNC_POL);
  localparam logic        VS_ON    = 1'(VSYNC_POL);

  logic [10:0] next_cy;

  always_comb begin
    next_cx = (cx == H_LAST) ? 12'd0 : cx + 12'd1;
    next_cy = cy;
    if (cx == H_LAST) begin
      next_cy = (cy == V_LAST) ? 11'd0 : cy + 11'd1;
    end
    next_active      = (next_cx < 12'(H_ACTIVE)) && (next_cy < 11'(V_ACTIVE));
    // Video preamble belongs to the line before each active line, including the frame's last line.
    next_line_active = (next_cy < 11'(V_ACTIVE - 1)) || (next_cy == V_LAST);
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      cx    <= 12'(H_ACTIVE);
      cy    <= 11'(V_ACTIVE);
      hsync <= ~HS_ON;
      vsync <= ~VS_ON;
    end else begin
      cx    <= next_cx;
      cy    <= next_cy;
      hsync <= (next_cx >= HS_FIRST && next_cx <= HS_LAST) ? HS_ON : ~HS_ON;
      vsync <= (next_cy >= VS_FIRST && next_cy <= VS_LAST) ? VS_ON : ~VS_ON;
    end
  end

endmodule

// File: rtl/hdmi_period_scheduler.sv
// Per-pixel HDMI period selection: video preamble/guard, data-island FSM and the
// control words for TMDS channels 1 and 2, all registered with the presented pixel.
module hdmi_period_scheduler
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int HSYNC_POL   = 0,
  parameter int VSYNC_POL   = 0,
  parameter int MAX_PACKETS = 18,
  parameter int DVI_OUTPUT  = 0
) (
  input  logic          clk_pixel,
  input  logic          reset,
  input  logic          packet_req,
  output logic [11:0]   cx,
  output logic [10:0]   cy,
  output logic          hsync,
  output logic          vsync,
  output logic [2:0]    mode,
  output logic [1:0]    ctl1,
  output logic [1:0]    ctl2,
  output logic          packet_start,
  output logic [4:0]    packet_px,
  output island_state_t island_state
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int H_BLANK = H_TOTAL - H_ACTIVE;
  localparam int N_FIT   = (H_BLANK - 30) / 32;
  localparam int N_MAX   = (N_FIT < MAX_PACKETS) ? N_FIT : MAX_PACKETS;

  localparam bit          ISLANDS_EN   = (N_MAX >= 1) && (DVI_OUTPUT == 0);
  localparam bit          PREAMBLES_EN = (DVI_OUTPUT == 0);
  localparam logic [4:0]  N_MAX_C      = 5'((N_MAX < 1) ? 1 : ((N_MAX > 31) ? 31 : N_MAX));
  localparam logic [11:0] ENTRY_CX     = 12'(H_ACTIVE + 3);
  localparam logic [11:0] VPRE_CX      = 12'(H_TOTAL - 10);
  localparam logic [11:0] VGUARD_CX    = 12'(H_TOTAL - 2);
  localparam logic [4:0]  PRE_LAST     = 5'(PREAMBLE_LEN - 1);
  localparam logic [4:0]  GUARD_LAST   = 5'(GUARD_LEN - 1);
  localparam logic [4:0]  PKT_LAST     = 5'(PACKET_LEN - 1);

  logic [11:0]   next_cx;
  logic          next_active;
  logic          next_line_active;
  island_state_t state, state_n;
  logic [4:0]    phase, phase_n;
  logic [4:0]    pkt_count, pkt_count_n;
  logic [2:0]    mode_n;
  ctl_pair_t     ctl_n;
  logic          start_n;
  logic [4:0]    px_n;

  hdmi_timing_counter #(
    .H_ACTIVE (H_ACTIVE), .H_FRONT (H_FRONT), .H_SYNC (H_SYNC), .H_BACK (H_BACK),
    .V_ACTIVE (V_ACTIVE), .V_FRONT (V_FRONT), .V_SYNC (V_SYNC), .V_BACK (V_BACK),
    .HSYNC_POL(HSYNC_POL), .VSYNC_POL(VSYNC_POL)
  ) u_timing (
    .clk_pixel       (clk_pixel),
    .reset           (reset),
    .cx              (cx),
    .cy              (cy),
    .hsync           (hsync),
    .vsync           (vsync),
    .next_cx         (next_cx),
    .next_active     (next_active),
    .next_line_active(next_line_active)
  );

  assign island_state = state;

  // state/phase/pkt_count describe the presented pixel; the *_n values describe the next one.
  always_comb begin
    state_n     = state;
    phase_n     = phase + 5'd1;
    pkt_count_n = pkt_count;
    case (state)
      ISL_IDLE: begin
        phase_n = 5'd0;
        if (ISLANDS_EN && cx == ENTRY_CX && packet_req) begin
          state_n = ISL_PREAMBLE;
        end
      end
      ISL_PREAMBLE: begin
        if (phase == PRE_LAST) begin
          state_n = ISL_LEAD_GUARD;
          phase_n = 5'd0;
        end
      end
      ISL_LEAD_GUARD: begin
        if (phase == GUARD_LAST) begin
          state_n     = ISL_PACKET;
          phase_n     = 5'd0;
          pkt_count_n = 5'd1;
        end
      end
      ISL_PACKET: begin
        if (phase == PKT_LAST) begin
          phase_n = 5'd0;
          if (packet_req && pkt_count < N_MAX_C) begin
            pkt_count_n = pkt_count + 5'd1;
          end else begin
            state_n = ISL_TRAIL_GUARD;
          end
        end
      end
      ISL_TRAIL_GUARD: begin
        if (phase == GUARD_LAST) begin
          state_n = ISL_IDLE;
          phase_n = 5'd0;
        end
      end
      default: begin
        state_n = ISL_IDLE;
        phase_n = 5'd0;
      end
    endcase

    mode_n  = MODE_CONTROL;
    ctl_n   = CTL_NONE;
    start_n = 1'b0;
    px_n    = 5'd0;
    if (next_active) begin
      mode_n = MODE_VIDEO;
    end else begin
      case (state_n)
        ISL_PREAMBLE:    ctl_n = CTL_ISLAND_PRE;
        ISL_LEAD_GUARD,
        ISL_TRAIL_GUARD: mode_n = MODE_ISLAND_GUARD;
        ISL_PACKET: begin
          mode_n  = MODE_ISLAND;
          start_n = (phase_n == 5'd0);
          px_n    = phase_n;
        end
        default: begin
          if (PREAMBLES_EN && next_line_active) begin
            if (next_cx >= VGUARD_CX) begin
              mode_n = MODE_VIDEO_GUARD;
            end else if (next_cx >= VPRE_CX) begin
              ctl_n = CTL_VIDEO_PRE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state        <= ISL_IDLE;
      phase        <= 5'd0;
      pkt_count    <= 5'd0;
      mode         <= MODE_CONTROL;
      ctl1         <= 2'b00;
      ctl2         <= 2'b00;
      packet_start <= 1'b0;
      packet_px    <= 5'd0;
    end else begin
      state        <= state_n;
      phase        <= phase_n;
      pkt_count    <= pkt_count_n;
      mode         <= mode_n;
      ctl1         <= ctl_n.ctl1;
      ctl2         <= ctl_n.ctl2;
      packet_start <= start_n;
      packet_px    <= px_n;
    end
  end

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Bench for hdmi_period_scheduler: default timing, a reduced raster with a packet
// limit, and a reduced DVI raster, each tracked by a behavioural raster model.
module tb_hdmi_period_scheduler;
  import hdmi_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk_pixel = 1'b0;
  logic reset = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, req2 = 1'b1;
  always #5 clk_pixel = ~clk_pixel;

  typedef struct packed {
    logic [11:0] cx;
    logic [10:0] cy;
    logic        hs;
    logic        vs;
    logic [2:0]  mode;
    logic [1:0]  ctl1;
    logic [1:0]  ctl2;
    logic        pstart;
    logic [4:0]  ppx;
  } out_t;

  out_t act0, act1, act2;
  island_state_t st0, st1, st2;

  hdmi_period_scheduler u_dut (
    .clk_pixel(clk_pixel), .reset(reset), .packet_req(req0),
    .cx(act0.cx), .cy(act0.cy), .hsync(act0.hs), .vsync(act0.vs), .mode(act0.mode),
    .ctl1(act0.ctl1), .ctl2(act0.ctl2), .packet_start(act0.pstart), .packet_px(act0.ppx),
    .island_state(st0));

  hdmi_period_scheduler #(
    .H_ACTIVE(64), .H_FRONT(16), .H_SYNC(40), .H_BACK(72),
    .V_ACTIVE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .MAX_PACKETS(2)
  ) u_small (
    .clk_pixel(clk_pixel), .reset(reset), .packet_req(req1),
    .cx(act1.cx), .cy(act1.cy), .hsync(act1.hs), .vsync(act1.vs), .mode(act1.mode),
    .ctl1(act1.ctl1), .ctl2(act1.ctl2), .packet_start(act1.pstart), .packet_px(act1.ppx),
    .island_state(st1));

  hdmi_period_scheduler #(
    .H_ACTIVE(64), .H_FRONT(16), .H_SYNC(40), .H_BACK(72),
    .V_ACTIVE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .MAX_PACKETS(2), .DVI_OUTPUT(1)
  ) u_dvi (
    .clk_pixel(clk_pixel), .reset(reset), .packet_req(req2),
    .cx(act2.cx), .cy(act2.cy), .hsync(act2.hs), .vsync(act2.vs), .mode(act2.mode),
    .ctl1(act2.ctl1), .ctl2(act2.ctl2), .packet_start(act2.pstart), .packet_px(act2.ppx),
    .island_state(st2));

  // ---------------- reference model ----------------
  typedef struct {
    int ha, hf, hsw, hb, va, vf, vsw, vb, maxp;
    bit dvi;
  } cfg_t;

  typedef struct {
    int x, y, pk;
    bit isl;
  } mst_t;

  cfg_t c0, c1, c2;
  mst_t m0, m1, m2;

  function automatic int n_max(input cfg_t c);
    int nfit, m;
    nfit = (c.hf + c.hsw + c.hb - 30) / 32;
    m = (nfit < c.maxp) ? nfit : c.maxp;
    return (c.dvi || m < 1) ? 0 : m;
  endfunction

  function automatic mst_t mreset(input cfg_t c);
    mst_t s;
    s.x = c.ha; s.y = c.va; s.pk = 0; s.isl = 1'b0;
    return s;
  endfunction

  function automatic mst_t mupd(input cfg_t c, input mst_t s, input logic rst, input logic req);
    mst_t n;
    int ht, vt, off;
    ht = c.ha + c.hf + c.hsw + c.hb;
    vt = c.va + c.vf + c.vsw + c.vb;
    n = s;
    if (rst) return mreset(c);
    if (!s.isl && n_max(c) > 0 && s.x == c.ha + 3 && req) begin
      n.isl = 1'b1; n.pk = 1;
    end else if (s.isl && s.x >= c.ha + 4) begin
      off = s.x - c.ha - 4;
      if (off >= 10 && off < 10 + 32 * s.pk && (off - 10) % 32 == 31 && req && s.pk < n_max(c))
        n.pk = s.pk + 1;
    end
    if (s.x == ht - 1) begin
      n.x = 0; n.isl = 1'b0;
      n.y = (s.y == vt - 1) ? 0 : s.y + 1;
    end else begin
      n.x = s.x + 1;
    end
    return n;
  endfunction

  function automatic out_t mout(input cfg_t c, input mst_t s);
    out_t o;
    int ht, vt, off;
    bit in_isl;
    ht = c.ha + c.hf + c.hsw + c.hb;
    vt = c.va + c.vf + c.vsw + c.vb;
    o = '0;
    o.cx = 12'(s.x);
    o.cy = 11'(s.y);
    o.hs = (s.x >= c.ha + c.hf && s.x < c.ha + c.hf + c.hsw) ? 1'b0 : 1'b1;
    o.vs = (s.y >= c.va + c.vf && s.y < c.va + c.vf + c.vsw) ? 1'b0 : 1'b1;
    in_isl = 1'b0;
    if (s.x < c.ha && s.y < c.va) begin
      o.mode = 3'd1;
    end else begin
      if (s.isl && s.x >= c.ha + 4) begin
        off = s.x - c.ha - 4;
        in_isl = 1'b1;
        if (off < 8) begin
          o.ctl1 = 2'b01; o.ctl2 = 2'b01;
        end else if (off < 10) begin
          o.mode = 3'd4;
        end else if (off < 10 + 32 * s.pk) begin
          o.mode = 3'd3;
          o.ppx = 5'((off - 10) % 32);
          o.pstart = ((off - 10) % 32 == 0);
        end else if (off < 12 + 32 * s.pk) begin
          o.mode = 3'd4;
        end else begin
          in_isl = 1'b0;
        end
      end
      if (!in_isl && !c.dvi && (s.y < c.va - 1 || s.y == vt - 1)) begin
        if (s.x >= ht - 2) o.mode = 3'd2;
        else if (s.x >= ht - 10) o.ctl1 = 2'b01;
      end
    end
    return o;
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0, failures = 0, ncycles = 0, phase = 0;
  int cnt480 = 0, cnt481 = 0, fp_cnt = 0;
  bit fp_valid = 1'b0;

  typedef struct {
    int ph, y, x;
    logic [2:0] mode;
    logic [1:0] c1, c2;
    logic ps, hs, vs;
  } vec_t;
  vec_t tbl[$];
  bit hit[$];

  function automatic void add(input int ph, input int y, input int x, input int md, input int k1,
                              input int k2, input int ps, input int hs, input int vs);
    vec_t v;
    v.ph = ph; v.y = y; v.x = x; v.mode = 3'(md); v.c1 = 2'(k1); v.c2 = 2'(k2);
    v.ps = 1'(ps); v.hs = 1'(hs); v.vs = 1'(vs);
    tbl.push_back(v);
    hit.push_back(1'b0);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, ncycles, act, exp);
    end
  endtask

  task automatic check_all();
    chk("sched_default", 64'(act0), 64'(mout(c0, m0)));
    chk("sched_small", 64'(act1), 64'(mout(c1, m1)));
    chk("sched_dvi", 64'(act2), 64'(mout(c2, m2)));
    chk("dvi_invariant", {58'd0, (act2.mode <= 3'd1), act2.ctl1, act2.ctl2, act2.pstart},
        {58'd0, 1'b1, 2'b00, 2'b00, 1'b0});
    foreach (tbl[i]) begin
      if (tbl[i].ph == phase && tbl[i].y == m0.y && tbl[i].x == m0.x) begin
        hit[i] = 1'b1;
        chk($sformatf("vec%0d_y%0d_x%0d", i, tbl[i].y, tbl[i].x),
            {54'd0, act0.mode, act0.ctl1, act0.ctl2, act0.pstart, act0.hs, act0.vs},
            {54'd0, tbl[i].mode, tbl[i].c1, tbl[i].c2, tbl[i].ps, tbl[i].hs, tbl[i].vs});
      end
    end
    if (phase == 1 && act0.pstart) begin
      if (m0.y == 480) cnt480++;
      else if (m0.y == 481) cnt481++;
    end
    if (act1.cx == 12'd0 && act1.cy == 11'd0) begin
      if (fp_valid) chk("small_frame_period", 64'(fp_cnt), 64'd2880);
      fp_valid = 1'b1;
      fp_cnt = 0;
    end
    fp_cnt++;
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic rst, input logic r0);
    logic r1;
    check_all();
    r1 = 1'($urandom_range(0, 1));
    m0 = mupd(c0, m0, rst, r0);
    m1 = mupd(c1, m1, rst, r1);
    m2 = mupd(c2, m2, rst, 1'b1);
    if (rst) fp_valid = 1'b0;
    reset = rst; req0 = r0; req1 = r1; req2 = 1'b1;
    @(negedge clk_pixel);
    ncycles++;
  endtask

  initial begin
    c0 = '{640, 16, 96, 48, 480, 10, 2, 33, 18, 1'b0};
    c1 = '{64, 16, 40, 72, 8, 2, 2, 3, 2, 1'b0};
    c2 = '{64, 16, 40, 72, 8, 2, 2, 3, 2, 1'b1};
    m0 = mreset(c0); m1 = mreset(c1); m2 = mreset(c2);

    // phase 0: idle line 480 / phase 1: full island then early stop
    add(0, 480, 640, 0, 0, 0, 0, 1, 1); add(0, 480, 644, 0, 0, 0, 0, 1, 1);
    add(0, 480, 655, 0, 0, 0, 0, 1, 1); add(0, 480, 656, 0, 0, 0, 0, 0, 1);
    add(0, 480, 751, 0, 0, 0, 0, 0, 1); add(0, 480, 752, 0, 0, 0, 0, 1, 1);
    add(0, 480, 799, 0, 0, 0, 0, 1, 1);
    add(1, 480, 644, 0, 1, 1, 0, 1, 1); add(1, 480, 651, 0, 1, 1, 0, 1, 1);
    add(1, 480, 652, 4, 0, 0, 0, 1, 1); add(1, 480, 653, 4, 0, 0, 0, 1, 1);
    add(1, 480, 654, 3, 0, 0, 1, 1, 1); add(1, 480, 655, 3, 0, 0, 0, 1, 1);
    add(1, 480, 686, 3, 0, 0, 1, 0, 1); add(1, 480, 718, 3, 0, 0, 1, 0, 1);
    add(1, 480, 750, 3, 0, 0, 1, 0, 1); add(1, 480, 781, 3, 0, 0, 0, 1, 1);
    add(1, 480, 782, 4, 0, 0, 0, 1, 1); add(1, 480, 783, 4, 0, 0, 0, 1, 1);
    add(1, 480, 784, 0, 0, 0, 0, 1, 1); add(1, 480, 799, 0, 0, 0, 0, 1, 1);
    add(1, 481, 686, 3, 0, 0, 1, 0, 1); add(1, 481, 717, 3, 0, 0, 0, 0, 1);
    add(1, 481, 718, 4, 0, 0, 0, 0, 1); add(1, 481, 719, 4, 0, 0, 0, 0, 1);
    add(1, 481, 720, 0, 0, 0, 0, 0, 1);
    // phase 2/3: reset mid-island and recovery
    add(2, 482, 654, 3, 0, 0, 1, 1, 1); add(2, 482, 700, 3, 0, 0, 0, 0, 1);
    add(3, 480, 640, 0, 0, 0, 0, 1, 1); add(3, 480, 644, 0, 1, 1, 0, 1, 1);
    add(3, 480, 654, 3, 0, 0, 1, 1, 1);
    // phase 4: vertical sync, last-line preamble, first active pixel
    add(4, 489, 799, 0, 0, 0, 0, 1, 1); add(4, 490, 0, 0, 0, 0, 0, 1, 0);
    add(4, 491, 799, 0, 0, 0, 0, 1, 0); add(4, 492, 0, 0, 0, 0, 0, 1, 1);
    add(4, 524, 790, 0, 1, 0, 0, 1, 1); add(4, 524, 797, 0, 1, 0, 0, 1, 1);
    add(4, 524, 798, 2, 0, 0, 0, 1, 1); add(4, 524, 799, 2, 0, 0, 0, 1, 1);
    add(4, 0, 0, 1, 0, 0, 0, 1, 1);

    @(negedge clk_pixel);
    @(negedge clk_pixel);
    chk("reset_outputs", 64'(act0), 64'({12'd640, 11'd480, 1'b1, 1'b1, 3'd0, 2'd0, 2'd0, 1'b0, 5'd0}));
    chk("reset_fsm_idle", 64'(st0), 64'(ISL_IDLE));

    phase = 0;
    while (!(m0.y == 481 && m0.x == 0)) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b1);

    phase = 1;
    while (!(m0.y == 482 && m0.x == 0)) cycle(1'b0, !(m0.y == 481 && m0.x >= 717));
    chk("packets_line480", 64'(cnt480), 64'd4);
    chk("packets_line481", 64'(cnt481), 64'd2);

    phase = 2;
    while (!(m0.y == 482 && m0.x == 700)) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);

    phase = 3;
    while (!(m0.y == 481 && m0.x == 0)) cycle(1'b0, 1'b1);

    phase = 4;
    while (!(m0.y == 0 && m0.x == 5)) cycle(1'b0, 1'($urandom_range(0, 1)));
    check_all();

    foreach (hit[i]) chk($sformatf("vec%0d_reached", i), 64'(hit[i]), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
